// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Operand/result bundle and start/busy/done handshake for serial_adder.
//   start : request a new operation (sampled by the adder only when idle)
//   A, B  : operands, captured on accept
//   Sub   : 1 = A - B, 0 = A + B (ignored unless SERIAL_ADDER_SUB_EN)
//   Sum   : result, valid from the done cycle until the next accept
//   Cout  : carry out of the MSB (subtraction: 1 = no borrow)
//   Ovf   : two's-complement signed overflow
//   busy  : operation in flight
//   done  : one-cycle result-valid pulse
// master = requester (control unit / testbench), slave = serial_adder.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Sub,
    input  Sum, Cout, Ovf, busy, done
  );

  modport slave (
    input  start, A, B, Sub,
    output Sum, Cout, Ovf, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor: one operand bit pair per clock goes through a
// single full_adder cell, with the cell's carry registered back into its
// carry-in for the next bit. Result appears WIDTH+1 cycles after accept.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : serial_adder_if.slave (start/A/B/Sub in, Sum/Cout/Ovf/busy/done out)
//
// Parameter:
//   WIDTH : operand/result width, >= 2
//
// Build option:
//   SERIAL_ADDER_SUB_EN : when defined, Sub selects A - B (B inverted at
//                         capture, carry seeded with 1). When undefined, Sub
//                         is ignored and every operation is A + B.
// -----------------------------------------------------------------------------

// Single-bit full adder cell.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-2:0] r_rs;     // sum bits collected so far, newest at the top
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_rs_next;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_c_seed;

  full_adder u_fa (
    .i_a   (r_ra[0]),
    .i_b   (r_rb[0]),
    .i_cin (r_c),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Result shift register after this bit: new sum bit enters at the MSB.
  // On the last bit this is the complete result.
  assign w_rs_next = {w_sum, r_rs};

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1: invert at capture, seed the carry with 1.
  assign w_b_cap  = bus.Sub ? ~bus.B : bus.B;
  assign w_c_seed = bus.Sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = bus.Sub;
  assign w_b_cap      = bus.B;
  assign w_c_seed     = 1'b0;
`endif

  // NOTE: every register here sits in one clocked block and is assigned with
  // <= so all of them see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    // NOTE: the shift registers are reset along with the control state; it
    // costs nothing at this size and keeps simulation free of X on the cell.
    if (rst) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rs    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ra    <= bus.A;
            r_rb    <= w_b_cap;
            r_c     <= w_c_seed;
            r_cnt   <= '0;
            r_rs    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_rs  <= w_rs_next[WIDTH-1:1];
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // On the MSB, r_c is the carry into the MSB and w_cout the carry
            // out; they differ exactly when the signed result overflows.
            r_sum   <= w_rs_next;
            r_cout  <= w_cout;
            r_ovf   <= r_c ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Sum  = r_sum;
  assign bus.Cout = r_cout;
  assign bus.Ovf  = r_ovf;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
